// File: rtl/seq_pipe_delay_elastic.sv
// seq_pipe_delay_elastic
//
// An elastic, stallable N-cycle delay line. WIDTH-bit items move through
// DEPTH register stages. Each stage has a valid bit. Empty stages (bubbles)
// always accept, so items pack toward the output when the consumer stalls.
// The full capacity of DEPTH items is usable.
//
// Handshake: a transfer happens on any rising edge where val and rdy are
// both 1. The producer must not make in_val depend on in_rdy. The consumer
// may assert out_rdy whether or not out_val is set. The ready path is
// combinational from out_rdy to in_rdy. flush is synchronous, has priority
// over everything else, and blocks transfers on both sides for that cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (clears valid bits and data)
//   in_val   producer offers in_ this cycle
//   in_rdy   block accepts in_ this cycle
//   in_      input data
//   out_val  out carries a valid item
//   out_rdy  consumer accepts out this cycle
//   out      output data (last stage)
//   flush    synchronous discard of all contents
//   count    number of valid stages
module seq_pipe_delay_elastic #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];

  logic [DEPTH-1:0] w_en;
  logic             w_tail_full;
  logic [DEPTH-1:0] w_up_v;
  logic [WIDTH-1:0] w_up_d [DEPTH];

  // Upstream source of each stage: stage 0 takes the input, and every other
  // stage takes the stage before it.
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_up
      if (g == 0) begin : g_first
        assign w_up_v[g] = in_val;
        assign w_up_d[g] = in_;
      end else begin : g_rest
        assign w_up_v[g] = r_v[g-1];
        assign w_up_d[g] = r_d[g-1];
      end
    end
  endgenerate

  // en[i] = ~v[i] | en[i+1], with en[DEPTH] = out_rdy. Unrolled, this means
  // stage i may load unless every stage from i to the output is full and
  // the consumer is stalled. It is written as a running AND so the tools
  // see no self-referencing vector.
  always_comb begin
    w_en        = '0;
    w_tail_full = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_tail_full = w_tail_full & r_v[i];
      w_en[i]     = ~w_tail_full | out_rdy;
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(r_v[i]);
    end
  end

  assign in_rdy  = w_en[0] & ~flush;
  assign out_val = r_v[DEPTH-1] & ~flush;
  assign out     = r_d[DEPTH-1];

  // Data loads only when a valid item arrives, so a bubble passing through
  // does not disturb a stage's data. flush clears the valid bits and leaves
  // the data alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else if (flush) begin
      r_v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_en[i]) begin
          r_v[i] <= w_up_v[i];
          if (w_up_v[i]) begin
            r_d[i] <= w_up_d[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_pipe_delay_elastic.sv
// Testbench for seq_pipe_delay_elastic. It covers three instances:
// DEPTH=3/WIDTH=8, DEPTH=1/WIDTH=8 and DEPTH=8/WIDTH=32.
module tb_seq_pipe_delay_elastic;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        a_in_val, a_in_rdy, a_out_val, a_out_rdy, a_flush;
  logic [7:0]  a_in, a_out;
  logic [1:0]  a_count;

  logic        b_in_val, b_in_rdy, b_out_val, b_out_rdy, b_flush;
  logic [7:0]  b_in, b_out;
  logic [0:0]  b_count;

  logic        c_in_val, c_in_rdy, c_out_val, c_out_rdy, c_flush;
  logic [31:0] c_in, c_out;
  logic [3:0]  c_count;

  seq_pipe_delay_elastic #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_val(a_in_val), .in_rdy(a_in_rdy), .in_(a_in),
    .out_val(a_out_val), .out_rdy(a_out_rdy), .out(a_out), .flush(a_flush), .count(a_count)
  );

  seq_pipe_delay_elastic #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_val(b_in_val), .in_rdy(b_in_rdy), .in_(b_in),
    .out_val(b_out_val), .out_rdy(b_out_rdy), .out(b_out), .flush(b_flush), .count(b_count)
  );

  seq_pipe_delay_elastic #(.WIDTH(32), .DEPTH(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_val(c_in_val), .in_rdy(c_in_rdy), .in_(c_in),
    .out_val(c_out_val), .out_rdy(c_out_rdy), .out(c_out), .flush(c_flush), .count(c_count)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_tests;
  int n_fail;

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    a_in_val = 1'b1; a_in = 8'hAA;
    b_in_val = 1'b1; b_in = 8'hAA;
    c_in_val = 1'b1; c_in = 32'hAAAA_AAAA;
    @(negedge clk);
    n_tests++;
    if (a_out_val !== 1'b0 || a_out !== 8'h00 || a_count !== 2'd0 || a_in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold_d3: out_val=%b out=%h count=%0d in_rdy=%b, expected 0/00/0/1",
               a_out_val, a_out, a_count, a_in_rdy);
    end
    n_tests++;
    if (b_out_val !== 1'b0 || b_out !== 8'h00 || b_count !== 1'd0 || b_in_rdy !== 1'b1 ||
        c_out_val !== 1'b0 || c_out !== 32'h0 || c_count !== 4'd0 || c_in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold_d1_d8: d1 %b/%h/%0d/%b d8 %b/%h/%0d/%b, expected 0/0/0/1",
               b_out_val, b_out, b_count, b_in_rdy, c_out_val, c_out, c_count, c_in_rdy);
    end
    a_in_val = 1'b0; b_in_val = 1'b0; c_in_val = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_tests++;
      if (a_out_val !== 1'b0 || a_out !== 8'h00 || a_count !== 2'd0 || a_in_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: out_val=%b out=%h count=%0d in_rdy=%b, expected 0/00/0/1",
                 k, a_out_val, a_out, a_count, a_in_rdy);
      end
    end
  endtask

  task automatic test_pure_delay();
    a_out_rdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_tests++;
      if (c >= 3 && c <= 10) begin
        if (a_out_val !== 1'b1 || a_out !== 8'(c - 2)) begin
          n_fail++;
          $display("FAIL pure_delay cycle %0d: out_val=%b out=%h, expected 1/%h", c, a_out_val, a_out, 8'(c - 2));
        end
      end else if (a_out_val !== 1'b0) begin
        n_fail++;
        $display("FAIL pure_delay cycle %0d: out_val=%b, expected 0", c, a_out_val);
      end
      if (c < 8) begin
        a_in_val = 1'b1; a_in = 8'(c + 1);
        #1;
        n_tests++;
        if (a_in_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL pure_delay_in_rdy cycle %0d: in_rdy=%b, expected 1", c, a_in_rdy);
        end
      end else begin
        a_in_val = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bp [4];
    bp[0] = 8'h11; bp[1] = 8'h22; bp[2] = 8'h33; bp[3] = 8'h44;
    @(negedge clk);
    a_out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in_val = 1'b1; a_in = bp[k];
      #1;
      n_tests++;
      if (a_in_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_accept item %0d: in_rdy=%b, expected 1", k, a_in_rdy);
      end
      @(negedge clk);
    end
    a_in = 8'h44;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_tests++;
      if (a_count !== 2'd3 || a_in_rdy !== 1'b0 || a_out_val !== 1'b1 || a_out !== 8'h11) begin
        n_fail++;
        $display("FAIL bp_full cycle %0d: count=%0d in_rdy=%b out_val=%b out=%h, expected 3/0/1/11",
                 k, a_count, a_in_rdy, a_out_val, a_out);
      end
      @(negedge clk);
    end
    a_out_rdy = 1'b1;
    #1;
    n_tests++;
    if (a_in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full_rdy: in_rdy=%b, expected 1", a_in_rdy);
    end
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 1) begin
        a_in_val = 1'b0;
        n_tests++;
        if (a_count !== 2'd3) begin
          n_fail++;
          $display("FAIL bp_push_pop_count: count=%0d, expected 3", a_count);
        end
      end
      #1;
      n_tests++;
      if (a_out_val !== 1'b1 || a_out !== bp[j]) begin
        n_fail++;
        $display("FAIL bp_drain item %0d: out_val=%b out=%h, expected 1/%h", j, a_out_val, a_out, bp[j]);
      end
    end
    @(negedge clk);
    n_tests++;
    if (a_out_val !== 1'b0 || a_count !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_empty: out_val=%b count=%0d, expected 0/0", a_out_val, a_count);
    end
  endtask

  task automatic test_bubble_collapse();
    @(negedge clk);
    a_out_rdy = 1'b1; a_in_val = 1'b1; a_in = 8'h5A;
    @(negedge clk);
    a_in_val = 1'b0;
    @(negedge clk);
    a_in_val = 1'b1; a_in = 8'h5B;
    @(negedge clk);
    a_in_val = 1'b0; a_out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (a_count !== 2'd2 || a_in_rdy !== 1'b1 || a_out_val !== 1'b1 || a_out !== 8'h5A) begin
      n_fail++;
      $display("FAIL bubble_pack: count=%0d in_rdy=%b out_val=%b out=%h, expected 2/1/1/5a",
               a_count, a_in_rdy, a_out_val, a_out);
    end
    a_out_rdy = 1'b1;
    @(negedge clk);
    n_tests++;
    if (a_out_val !== 1'b1 || a_out !== 8'h5B) begin
      n_fail++;
      $display("FAIL bubble_second: out_val=%b out=%h, expected 1/5b", a_out_val, a_out);
    end
    @(negedge clk);
    n_tests++;
    if (a_out_val !== 1'b0 || a_count !== 2'd0) begin
      n_fail++;
      $display("FAIL bubble_empty: out_val=%b count=%0d, expected 0/0", a_out_val, a_count);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    a_out_rdy = 1'b0; a_in_val = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_in = 8'(8'hA1 + k);
      @(negedge clk);
    end
    a_in = 8'hFF; a_flush = 1'b1; a_out_rdy = 1'b1;
    #1;
    n_tests++;
    if (a_count !== 2'd3 || a_in_rdy !== 1'b0 || a_out_val !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle: count=%0d in_rdy=%b out_val=%b, expected 3/0/0", a_count, a_in_rdy, a_out_val);
    end
    @(negedge clk);
    a_flush = 1'b0; a_in_val = 1'b0;
    n_tests++;
    if (a_count !== 2'd0 || a_out_val !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after: count=%0d out_val=%b, expected 0/0", a_count, a_out_val);
    end
    a_in_val = 1'b1; a_in = 8'h77;
    #1;
    n_tests++;
    if (a_in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_push_rdy: in_rdy=%b, expected 1", a_in_rdy);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      a_in_val = 1'b0;
      n_tests++;
      if (c == 3) begin
        if (a_out_val !== 1'b1 || a_out !== 8'h77) begin
          n_fail++;
          $display("FAIL flush_refill: out_val=%b out=%h, expected 1/77", a_out_val, a_out);
        end
      end else if (a_out_val !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_refill_gap cycle %0d: out_val=%b, expected 0", c, a_out_val);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a_out_rdy = 1'b0; a_in_val = 1'b1; a_in = 8'hC1;
    @(negedge clk);
    a_in = 8'hC2;
    @(negedge clk);
    a_in_val = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_count !== 2'd2 || a_out_val !== 1'b1 || a_out !== 8'hC1) begin
      n_fail++;
      $display("FAIL areset_pre: count=%0d out_val=%b out=%h, expected 2/1/c1", a_count, a_out_val, a_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (a_out_val !== 1'b0 || a_out !== 8'h00 || a_count !== 2'd0) begin
      n_fail++;
      $display("FAIL areset_immediate: out_val=%b out=%h count=%0d, expected 0/00/0", a_out_val, a_out, a_count);
    end
    @(negedge clk);
    rst_n = 1'b1; a_out_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (a_out_val !== 1'b0 || a_count !== 2'd0 || a_out !== 8'h00) begin
        n_fail++;
        $display("FAIL areset_leftover cycle %0d: out_val=%b count=%0d out=%h, expected 0/0/00",
                 k, a_out_val, a_count, a_out);
      end
    end
  endtask

  task automatic test_depth1();
    logic [31:0] e;
    b_out_rdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_tests++;
      if (int'(b_count) != exp_q.size() || b_out_val !== (c >= 1 && c <= 10)) begin
        n_fail++;
        $display("FAIL d1_stream cycle %0d: count=%0d out_val=%b, expected %0d/%b",
                 c, b_count, b_out_val, exp_q.size(), (c >= 1 && c <= 10));
      end
      if (c < 10) begin
        b_in_val = 1'b1; b_in = 8'($urandom_range(0, 255));
      end else begin
        b_in_val = 1'b0;
      end
      #1;
      if (c < 10) begin
        n_tests++;
        if (b_in_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL d1_in_rdy cycle %0d: in_rdy=%b, expected 1", c, b_in_rdy);
        end
      end
      if (b_out_val && b_out_rdy) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL d1_data: unexpected out=%h, expected nothing", b_out);
        end else begin
          e = exp_q.pop_front();
          if (b_out !== e[7:0]) begin
            n_fail++;
            $display("FAIL d1_data: out=%h, expected %h", b_out, e[7:0]);
          end
        end
      end
      if (b_in_val && b_in_rdy) exp_q.push_back(32'(b_in));
    end
    // A single register: in_rdy is ~v | out_rdy.
    @(negedge clk);
    b_out_rdy = 1'b0; b_in_val = 1'b1; b_in = 8'h3C;
    @(negedge clk);
    b_in = 8'h3D;
    #1;
    n_tests++;
    if (b_in_rdy !== 1'b0 || b_out_val !== 1'b1 || b_out !== 8'h3C) begin
      n_fail++;
      $display("FAIL d1_stall: in_rdy=%b out_val=%b out=%h, expected 0/1/3c", b_in_rdy, b_out_val, b_out);
    end
    b_out_rdy = 1'b1;
    #1;
    n_tests++;
    if (b_in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL d1_full_rdy: in_rdy=%b, expected 1", b_in_rdy);
    end
    @(negedge clk);
    b_in_val = 1'b0;
    n_tests++;
    if (b_out_val !== 1'b1 || b_out !== 8'h3D) begin
      n_fail++;
      $display("FAIL d1_second: out_val=%b out=%h, expected 1/3d", b_out_val, b_out);
    end
    @(negedge clk);
    n_tests++;
    if (b_out_val !== 1'b0 || b_count !== 1'd0) begin
      n_fail++;
      $display("FAIL d1_empty: out_val=%b count=%0d, expected 0/0", b_out_val, b_count);
    end
  endtask

  task automatic test_depth8();
    logic [31:0] e;
    bit          exp_v;
    // Phase 0: full-rate stream, latency 8. Phase 1: random valid and
    // random ready. Phase 2: drain.
    for (int c = 0; c < 105; c++) begin
      @(negedge clk);
      n_tests++;
      if (int'(c_count) != exp_q.size()) begin
        n_fail++;
        $display("FAIL d8_count cycle %0d: count=%0d, expected %0d", c, c_count, exp_q.size());
      end
      if (c < 25) begin
        exp_v = (c >= 8 && c <= 23);
        n_tests++;
        if (c_out_val !== exp_v) begin
          n_fail++;
          $display("FAIL d8_stream_valid cycle %0d: out_val=%b, expected %b", c, c_out_val, exp_v);
        end
        c_out_rdy = 1'b1;
        c_in_val  = (c < 16);
      end else if (c < 85) begin
        c_out_rdy = 1'($urandom_range(0, 1));
        c_in_val  = 1'($urandom_range(0, 1));
      end else begin
        c_out_rdy = 1'b1;
        c_in_val  = 1'b0;
      end
      c_in = $urandom();
      #1;
      if (c < 16) begin
        n_tests++;
        if (c_in_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL d8_in_rdy cycle %0d: in_rdy=%b, expected 1", c, c_in_rdy);
        end
      end
      if (c_out_val && c_out_rdy) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL d8_data cycle %0d: unexpected out=%h, expected nothing", c, c_out);
        end else begin
          e = exp_q.pop_front();
          if (c_out !== e) begin
            n_fail++;
            $display("FAIL d8_data cycle %0d: out=%h, expected %h", c, c_out, e);
          end
        end
      end
      if (c_in_val && c_in_rdy) exp_q.push_back(c_in);
    end
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0 || c_out_val !== 1'b0) begin
      n_fail++;
      $display("FAIL d8_drain: %0d items missing, out_val=%b, expected 0/0", exp_q.size(), c_out_val);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b1;
    a_in_val = 1'b0; a_in = '0; a_out_rdy = 1'b0; a_flush = 1'b0;
    b_in_val = 1'b0; b_in = '0; b_out_rdy = 1'b0; b_flush = 1'b0;
    c_in_val = 1'b0; c_in = '0; c_out_rdy = 1'b0; c_flush = 1'b0;
    #1;
    test_reset();
    test_pure_delay();
    test_backpressure();
    test_bubble_collapse();
    test_flush();
    test_async_reset();
    test_depth1();
    test_depth8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
